game_fsm: RTL and testbench



---
 rtl/game_fsm_if.sv | 24 ++
 rtl/game_fsm.sv | 144 ++++++++++++++
 tb/tb_game_fsm.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/game_fsm_if.sv
// Game sequencer bus: buttons and physics/pipe inputs toward the FSM, game status back out.
interface game_fsm_if;
  logic               start_btn;
  logic               pause_btn;
  logic signed [10:0] y_coord;
  logic        [10:0] pipe_x;
  logic        [10:0] gap_lo;
  logic        [10:0] gap_hi;
  logic        [1:0]  state;
  logic               enable;
  logic        [15:0] score;
  logic        [15:0] hi_score;
  logic               hit;

  modport master (
    output start_btn, pause_btn, y_coord, pipe_x, gap_lo, gap_hi,
    input  state, enable, score, hi_score, hit
  );

  modport slave (
    input  start_btn, pause_btn, y_coord, pipe_x, gap_lo, gap_hi,
    output state, enable, score, hi_score, hit
  );
endinterface

// File: rtl/game_fsm.sv
// Flappy-bird game sequencer: button sync, collision, BCD scoring, high score, lockout.
// Optional pipe collision enabled by defining GAME_FSM_PIPE_COLLISION_EN.
module game_fsm #(
  parameter logic [10:0] BIRD_X     = 11'd200,
  parameter logic [10:0] BIRD_W     = 11'd34,
  parameter logic [10:0] BIRD_H     = 11'd24,
  parameter logic [10:0] PIPE_W     = 11'd60,
  parameter logic [7:0]  OVER_TICKS = 8'd64,
  parameter int          TICK_LOG2  = 5
) (
  input  logic       clk,
  input  logic       rst,
  game_fsm_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READY = 2'd1, S_PLAY = 2'd2, S_OVER = 2'd3} state_t;

  state_t                 st;
  logic                   enable;
  logic [15:0]            score;
  logic [15:0]            hi_score;
  logic                   hit;
  logic [7:0]             lock;
  logic [TICK_LOG2-1:0]   tick_cnt;
  logic [10:0]            prev_pipe_x;
  logic                   start_p0, start_p1, start_p2;
  logic                   pause_p0, pause_p1, pause_p2;
  logic                   start_rise, pause_rise, tick;
  logic                   ground, coll, score_ev;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v == 16'h9999) return v;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Stage p0/p1: two-flop synchronizers; p2: edge-detect register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_p0 <= 1'b0; start_p1 <= 1'b0; start_p2 <= 1'b0;
      pause_p0 <= 1'b0; pause_p1 <= 1'b0; pause_p2 <= 1'b0;
      tick_cnt <= '0;
      prev_pipe_x <= '0;
    end else begin
      start_p0 <= bus.start_btn; start_p1 <= start_p0; start_p2 <= start_p1;
      pause_p0 <= bus.pause_btn; pause_p1 <= pause_p0; pause_p2 <= pause_p1;
      tick_cnt <= tick_cnt + 1'b1;
      prev_pipe_x <= bus.pipe_x;
    end
  end

  assign start_rise = start_p1 & ~start_p2;
  assign pause_rise = pause_p1 & ~pause_p2;
  assign tick       = &tick_cnt;
  assign ground     = (bus.y_coord <= 11'sd0);

`ifdef GAME_FSM_PIPE_COLLISION_EN
  logic signed [11:0] y_ext;
  logic               x_ovl, y_out;
  assign y_ext = {bus.y_coord[10], bus.y_coord};
  assign x_ovl = ({1'b0, bus.pipe_x} < ({1'b0, BIRD_X} + {1'b0, BIRD_W})) &&
                 (({1'b0, bus.pipe_x} + {1'b0, PIPE_W}) > {1'b0, BIRD_X});
  assign y_out = (y_ext < $signed({1'b0, bus.gap_lo})) ||
                 ((y_ext + $signed({1'b0, BIRD_H})) > $signed({1'b0, bus.gap_hi}));
  assign coll  = ground | (x_ovl & y_out);
`else
  logic unused_pipe;
  assign unused_pipe = ^{bus.gap_lo, bus.gap_hi, BIRD_W, BIRD_H};
  assign coll        = ground;
`endif

  // A crossing is the pipe's right edge passing the bird's left edge this cycle
  assign score_ev = (({1'b0, prev_pipe_x} + {1'b0, PIPE_W}) >= {1'b0, BIRD_X}) &&
                    (({1'b0, bus.pipe_x}  + {1'b0, PIPE_W}) <  {1'b0, BIRD_X});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= S_IDLE;
      enable   <= 1'b0;
      score    <= '0;
      hi_score <= '0;
      hit      <= 1'b0;
      lock     <= '0;
    end else begin
      hit <= 1'b0;
      case (st)
        S_IDLE: if (start_rise) begin
          st     <= S_READY;
          score  <= '0;
          enable <= 1'b1;
        end
        S_READY: if (start_rise) begin
          st     <= S_PLAY;
          enable <= 1'b1;
        end
        S_PLAY: begin
          if (enable && coll) begin
            st     <= S_OVER;
            hit    <= 1'b1;
            enable <= 1'b0;
            lock   <= OVER_TICKS;
          end else begin
            if (pause_rise) enable <= ~enable;
            if (enable && score_ev) score <= bcd_inc(score);
          end
        end
        S_OVER: begin
          // hit is high only in the first OVER cycle, so it marks entry
          if (hit && (score > hi_score)) hi_score <= score;
          if (lock == 8'd0) begin
            if (start_rise) begin
              st     <= S_READY;
              score  <= '0;
              enable <= 1'b1;
            end
          end else if (tick) begin
            lock <= lock - 8'd1;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign bus.state    = st;
  assign bus.enable   = enable;
  assign bus.score    = score;
  assign bus.hi_score = hi_score;
  assign bus.hit      = hit;

endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm: sequencing, lockout, scoring, pause, saturation, async reset.
module tb_game_fsm;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  bit   hit_seen;

  game_fsm_if bus ();

  game_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic press_start();
    bus.start_btn = 1'b1;
    cyc(3);
    bus.start_btn = 1'b0;
  endtask

  task automatic press_pause();
    bus.pause_btn = 1'b1;
    cyc(3);
    bus.pause_btn = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; hit_seen = 1'b0;
    rst = 1'b1;
    bus.start_btn = 1'b0; bus.pause_btn = 1'b0;
    bus.y_coord = 11'sd150; bus.pipe_x = 11'd640;
    bus.gap_lo = 11'd100; bus.gap_hi = 11'd300;
    cyc(2);
    chk("rst_state", bus.state, 0);
    chk("rst_enable", bus.enable, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_hi", bus.hi_score, 0);
    chk("rst_hit", bus.hit, 0);
    rst = 1'b0;
    cyc(1);

    // IDLE -> READY, 3 clk latency
    bus.start_btn = 1'b1;
    cyc(2);
    chk("idle_latency", bus.state, 0);
    cyc(1);
    chk("to_ready", bus.state, 1);
    chk("ready_enable", bus.enable, 1);
    chk("ready_score", bus.score, 0);
    bus.start_btn = 1'b0;
    cyc(3);
    press_start();
    chk("to_play", bus.state, 2);
    chk("play_enable", bus.enable, 1);
    cyc(3);

    // Pipe sweep: exactly one crossing at 140 -> 139
    for (int p = 300; p >= 100; p--) begin
      bus.pipe_x = 11'(p);
      cyc(1);
      if (bus.hit) hit_seen = 1'b1;
      if (p == 140) chk("pre_cross_score", bus.score, 16'h0000);
      if (p == 139) chk("cross_score", bus.score, 16'h0001);
    end
    chk("sweep_no_hit", hit_seen, 0);
    chk("sweep_state", bus.state, 2);
    bus.pipe_x = 11'd640;
    cyc(3);
    chk("respawn_score", bus.score, 16'h0001);

    // Pause freezes collision; unpause lets the hit through
    press_pause();
    chk("paused_enable", bus.enable, 0);
    bus.y_coord = 11'sd0;
    cyc(3);
    chk("paused_state", bus.state, 2);
    chk("paused_hit", bus.hit, 0);
    press_pause();
    chk("unpause_enable", bus.enable, 1);
    chk("unpause_state", bus.state, 2);
    cyc(1);
    chk("ground_over", bus.state, 3);
    chk("ground_hit", bus.hit, 1);
    cyc(1);
    chk("hit_drop", bus.hit, 0);
    chk("hi_update", bus.hi_score, 16'h0001);
    chk("over_enable", bus.enable, 0);

    // Lockout ignores early start
    bus.y_coord = 11'sd150;
    press_start();
    chk("lockout_ignore", bus.state, 3);
    cyc(2200);
    press_start();
    chk("over_to_ready", bus.state, 1);
    chk("ready_clear", bus.score, 0);
    chk("hi_keep", bus.hi_score, 16'h0001);
    cyc(3);
    press_start();
    chk("play2", bus.state, 2);
    cyc(3);

    // Pipe collision: top of bird above the gap
    bus.y_coord = 11'sd290;
    bus.pipe_x  = 11'd210;
    cyc(1);
`ifdef GAME_FSM_PIPE_COLLISION_EN
    chk("pipe_over", bus.state, 3);
    chk("pipe_hit", bus.hit, 1);
`else
    chk("pipe_ignored", bus.state, 2);
    cyc(3);
    chk("pipe_ignored2", bus.state, 2);
    bus.y_coord = 11'sd0;
    cyc(1);
    chk("ground_over2", bus.state, 3);
`endif
    cyc(1);
    chk("hi_not_lower", bus.hi_score, 16'h0001);

    bus.y_coord = 11'sd150;
    bus.pipe_x  = 11'd640;
    cyc(2200);
    press_start();
    cyc(3);
    press_start();
    cyc(3);
    chk("play3", bus.state, 2);
    chk("play3_score", bus.score, 0);

    // BCD carry chain and saturation
    for (int i = 1; i <= 10000; i++) begin
      bus.pipe_x = 11'd140;
      cyc(1);
      bus.pipe_x = 11'd139;
      cyc(1);
      if (i == 10)    chk("bcd_10", bus.score, 16'h0010);
      if (i == 100)   chk("bcd_100", bus.score, 16'h0100);
      if (i == 1999)  chk("bcd_1999", bus.score, 16'h1999);
      if (i == 9999)  chk("bcd_9999", bus.score, 16'h9999);
      if (i == 10000) chk("bcd_sat", bus.score, 16'h9999);
    end
    bus.y_coord = 11'sd0;
    cyc(1);
    chk("sat_over", bus.state, 3);
    cyc(1);
    chk("hi_9999", bus.hi_score, 16'h9999);

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", bus.state, 0);
    chk("arst_enable", bus.enable, 0);
    chk("arst_score", bus.score, 0);
    chk("arst_hi", bus.hi_score, 0);
    chk("arst_hit", bus.hit, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
